// File: rtl/step_dir_if.sv
// Command channel for the step/dir generator: one queued move per valid/ready handshake.
interface step_dir_if #(
  parameter int COUNT_W  = 32,
  parameter int PERIOD_W = 16
);
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_dir;
  logic [COUNT_W-1:0]  cmd_steps;
  logic [PERIOD_W-1:0] cmd_period;

  modport master (output cmd_valid, cmd_dir, cmd_steps, cmd_period, input cmd_ready);
  modport slave  (input cmd_valid, cmd_dir, cmd_steps, cmd_period, output cmd_ready);
endinterface

// File: rtl/step_dir_generator.sv
// Turns accepted move commands into a registered step/dir pulse train and tracks absolute position.
//   state      | meaning
//   IDLE       | ready for a command, no move in progress
//   DIR_SETUP  | dir just changed, step held low for SU ticks
//   PULSE_HIGH | step high for PW ticks
//   PULSE_LOW  | step low until the period counter expires
module step_dir_generator #(
  parameter int COUNT_W  = 32,
  parameter int PERIOD_W = 16,
  parameter int POS_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  step_dir_if.slave          cmd,
  input  logic [7:0]         config_pulse_width,
  input  logic [7:0]         config_dir_setup,
  input  logic               abort,
  input  logic               pos_load,
  input  logic [POS_W-1:0]   pos_load_value,
  output logic               step,
  output logic               dir,
  output logic               busy,
  output logic               done,
  output logic               done_aborted,
  output logic [COUNT_W-1:0] steps_remaining,
  output logic [POS_W-1:0]   position
);

  typedef enum logic [1:0] {IDLE, DIR_SETUP, PULSE_HIGH, PULSE_LOW} state_t;

  state_t              state, state_next;
  logic                ready;
  logic                abort_pend, abort_act;
  logic                accept, zero_cmd;
  logic [7:0]          pw_c, su_c, pw_eff, ph_cnt;
  logic [PERIOD_W-1:0] per_min, per_c, per_eff, per_cnt;
  logic                rise, exit_move, step_nx, done_nx, aborted_nx, ready_nx;
  logic [POS_W-1:0]    pos_base;

  assign cmd.cmd_ready = ready;
  assign busy          = (state != IDLE);
  assign accept        = (state == IDLE) && cmd.cmd_valid && ready;
  assign zero_cmd      = (cmd.cmd_steps == '0);
  assign abort_act     = abort || abort_pend;

  // Effective timing, clamped so the receiver's synchronisers always see both levels.
  always_comb begin
    pw_c    = (config_pulse_width == 8'd0) ? 8'd1 : config_pulse_width;
    su_c    = (config_dir_setup < 8'd2) ? 8'd2 : config_dir_setup;
    per_min = PERIOD_W'(pw_c) + PERIOD_W'(2);
    per_c   = (cmd.cmd_period < per_min) ? per_min : cmd.cmd_period;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && !zero_cmd)
          state_next = (cmd.cmd_dir == dir) ? PULSE_HIGH : DIR_SETUP;
      end
      DIR_SETUP: begin
        if (abort_act)            state_next = IDLE;
        else if (ph_cnt == 8'd0)  state_next = PULSE_HIGH;
      end
      PULSE_HIGH: begin
        if (ph_cnt == 8'd0)       state_next = abort_act ? IDLE : PULSE_LOW;
      end
      PULSE_LOW: begin
        if (abort_act)            state_next = IDLE;
        else if (per_cnt == '0)   state_next = (steps_remaining != '0) ? PULSE_HIGH : IDLE;
      end
      default:                    state_next = IDLE;
    endcase
  end

  always_comb begin
    rise       = (state_next == PULSE_HIGH) && (state != PULSE_HIGH);
    exit_move  = (state != IDLE) && (state_next == IDLE);
    step_nx    = (state_next == PULSE_HIGH);
    done_nx    = exit_move || (accept && zero_cmd);
    aborted_nx = exit_move && abort_act;
    ready_nx   = (state_next == IDLE);
    pos_base   = (state == IDLE && pos_load) ? pos_load_value : position;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step            <= 1'b0;
      dir             <= 1'b0;
      done            <= 1'b0;
      done_aborted    <= 1'b0;
      ready           <= 1'b0;
      steps_remaining <= '0;
      position        <= '0;
      abort_pend      <= 1'b0;
      pw_eff          <= 8'd1;
      per_eff         <= '0;
      ph_cnt          <= 8'd0;
      per_cnt         <= '0;
    end else begin
      step         <= step_nx;
      done         <= done_nx;
      done_aborted <= aborted_nx;
      ready        <= ready_nx;

      if (accept) begin
        pw_eff  <= pw_c;
        per_eff <= per_c;
        if (!zero_cmd) dir <= cmd.cmd_dir;
      end

      if (exit_move && abort_act)
        steps_remaining <= '0;
      else if (accept)
        steps_remaining <= rise ? cmd.cmd_steps - COUNT_W'(1) : cmd.cmd_steps;
      else if (rise)
        steps_remaining <= steps_remaining - COUNT_W'(1);

      // dir already equals the stepping direction on every rise edge
      if (rise) position <= dir ? pos_base + POS_W'(1) : pos_base - POS_W'(1);
      else      position <= pos_base;

      if (rise) begin
        ph_cnt  <= (accept ? pw_c : pw_eff) - 8'd1;
        per_cnt <= (accept ? per_c : per_eff) - PERIOD_W'(1);
      end else begin
        if (accept)              ph_cnt <= su_c - 8'd1;
        else if (ph_cnt != 8'd0) ph_cnt <= ph_cnt - 8'd1;
        if (per_cnt != '0)       per_cnt <= per_cnt - PERIOD_W'(1);
      end

      if (state_next == IDLE)               abort_pend <= 1'b0;
      else if (state != IDLE && abort)      abort_pend <= 1'b1;
    end
  end

endmodule
